// File: rtl/voice_fifo_rd_arb_if.sv
// Bus bundle between the voice prefetch FIFO read side, the arbiter and
// its two consumers. The arbiter connects through the master modport.
interface voice_fifo_rd_arb_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 11
);
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_rd_vld;
  logic              fifo_rd_en;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        m_vld;
  logic [1:0]        m_rdy;
  logic              m_last;
  logic [1:0]        frame_done;
  logic [CNT_W-1:0]  word_cnt;

  modport master (
    input  fifo_rd_data, fifo_rd_vld, req, m_rdy,
    output fifo_rd_en, gnt, m_data, m_vld, m_last, frame_done, word_cnt
  );

  modport slave (
    output fifo_rd_data, fifo_rd_vld, req, m_rdy,
    input  fifo_rd_en, gnt, m_data, m_vld, m_last, frame_done, word_cnt
  );
endinterface

// File: rtl/voice_fifo_rd_arb.sv
// Frame-granular read arbiter: pulls FRAME_LEN words from a prefetch FIFO
// for one of two consumers at a time, round-robin between frames, through
// a single registered output stage that can be refilled on the same cycle
// it is drained.
module voice_fifo_rd_arb #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 256,
  parameter int CNT_W     = 11
) (
  input logic                  i_rd_clk,
  input logic                  i_rd_rst,
  voice_fifo_rd_arb_if.master  io_bus
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [1:0]        r_gnt;
  logic              r_lastSel;
  logic              r_outFull;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [1:0]        r_frameDone;
  logic [CNT_W-1:0]  r_wordCnt;

  logic              w_sel;
  logic              w_grantSel;
  logic              w_rdEn;
  logic              w_pop;
  logic              w_endPop;
  logic              w_accept;
  logic [1:0]        w_mVld;
  logic [CNT_W-1:0]  w_cntInc;

  // The owner index is the upper grant bit because the grant is one-hot.
  assign w_sel      = r_gnt[1];
  assign w_grantSel = (io_bus.req == 2'b11) ? ~r_lastSel : io_bus.req[1];
  assign w_rdEn     = ~i_rd_rst && (r_state == XFER) &&
                      (~r_outFull || io_bus.m_rdy[w_sel]);
  assign w_pop      = w_rdEn && io_bus.fifo_rd_vld;
  assign w_cntInc   = r_wordCnt + 1'b1;
  assign w_endPop   = w_pop && (w_cntInc == CNT_W'(FRAME_LEN));
  assign w_mVld     = {2{r_outFull}} & r_gnt;
  assign w_accept   = |(w_mVld & io_bus.m_rdy);

  // Hold the frame-level state; reset aborts any frame in flight.
  always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
    if (i_rd_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Frame sequencing: grant, stream until the last pop, then wait for the last accept.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (|io_bus.req) w_nextState = XFER;
      XFER:    if (w_endPop)    w_nextState = DRAIN;
      DRAIN:   if (w_accept)    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Grant, output stage, word counter and done pulse bookkeeping.
  always_ff @(posedge i_rd_clk or posedge i_rd_rst) begin
    if (i_rd_rst) begin
      r_gnt       <= 2'b00;
      r_lastSel   <= 1'b1;
      r_outFull   <= 1'b0;
      r_data      <= '0;
      r_last      <= 1'b0;
      r_frameDone <= 2'b00;
      r_wordCnt   <= '0;
    end else begin
      r_frameDone <= 2'b00;
      case (r_state)
        IDLE: begin
          if (|io_bus.req) begin
            r_gnt     <= w_grantSel ? 2'b10 : 2'b01;
            r_wordCnt <= '0;
          end
        end
        XFER: begin
          if (w_pop) begin
            r_data    <= io_bus.fifo_rd_data;
            r_outFull <= 1'b1;
            r_wordCnt <= w_cntInc;
            r_last    <= w_endPop;
          end else if (w_accept) begin
            r_outFull <= 1'b0;
          end
        end
        DRAIN: begin
          if (w_accept) begin
            r_outFull   <= 1'b0;
            r_last      <= 1'b0;
            r_frameDone <= r_gnt;
            r_lastSel   <= w_sel;
            r_gnt       <= 2'b00;
          end
        end
        default: begin
          r_outFull <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.fifo_rd_en = w_rdEn;
  assign io_bus.gnt        = r_gnt;
  assign io_bus.m_data     = r_data;
  assign io_bus.m_vld      = w_mVld;
  assign io_bus.m_last     = r_last;
  assign io_bus.frame_done = r_frameDone;
  assign io_bus.word_cnt   = r_wordCnt;

endmodule

// File: tb/tb_voice_fifo_rd_arb.sv
// Directed bench for voice_fifo_rd_arb with FRAME_LEN = 4. A simple array
// stands in for the prefetch FIFO; every expected word is derived from the
// order in which words were pushed.
module tb_voice_fifo_rd_arb;
  localparam int DW = 32;
  localparam int FL = 4;
  localparam int CW = 11;
  localparam int VW = 2 + 2 + 1 + CW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  voice_fifo_rd_arb_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  voice_fifo_rd_arb #(.DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .i_rd_clk (clk),
    .i_rd_rst (rst),
    .io_bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fifoMem [0:63];
  int fifoWr = 0;
  int fifoRd = 0;
  int total  = 0;
  int bad    = 0;
  int expIdx = 0;
  logic [VW-1:0] gotV;
  logic [VW-1:0] expV;

  assign bus.fifo_rd_vld  = (fifoRd != fifoWr);
  assign bus.fifo_rd_data = fifoMem[fifoRd[5:0]];

  // FIFO model pops its head whenever the arbiter reads a valid word.
  always @(posedge clk) begin
    if (bus.fifo_rd_vld && bus.fifo_rd_en) fifoRd <= fifoRd + 1;
  end

  function automatic logic [DW-1:0] wordVal(input int n);
    return 32'hC0DE_0000 + DW'(n);
  endfunction

  task automatic pushWords(input int n);
    for (int k = 0; k < n; k++) begin
      fifoMem[fifoWr[5:0]] = wordVal(fifoWr);
      fifoWr = fifoWr + 1;
    end
  endtask

  task automatic test_reset;
    bus.req  = 2'b00;
    bus.m_rdy = 2'b00;
    rst = 1'b1;
    pushWords(4);
    repeat (2) @(negedge clk);
    total++;
    if ({bus.gnt, bus.m_vld, bus.m_last, bus.frame_done, bus.fifo_rd_en, bus.word_cnt, bus.m_data} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state got gnt=%b vld=%b last=%b done=%b rden=%b cnt=%0d data=%h want all zero",
               bus.gnt, bus.m_vld, bus.m_last, bus.frame_done, bus.fifo_rd_en, bus.word_cnt, bus.m_data);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.gnt, bus.fifo_rd_en} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL idle_no_pop got gnt=%b rden=%b want gnt=00 rden=0", bus.gnt, bus.fifo_rd_en);
    end
  endtask

  task automatic test_single_frame;
    bus.m_rdy = 2'b11;
    bus.req   = 2'b01;
    @(negedge clk);
    total++;
    if ({bus.gnt, bus.fifo_rd_en} !== 3'b011) begin
      bad++;
      $display("[TB] FAIL s1_grant got gnt=%b rden=%b want gnt=01 rden=1", bus.gnt, bus.fifo_rd_en);
    end
    bus.req = 2'b00;
    for (int i = 1; i <= FL; i++) begin
      @(negedge clk);
      gotV = {bus.gnt, bus.m_vld, bus.m_last, bus.word_cnt, bus.m_data};
      expV = {2'b01, 2'b01, (i == FL), CW'(i), wordVal(expIdx)};
      total++;
      if (gotV !== expV) begin
        bad++;
        $display("[TB] FAIL s1_word%0d got=%h want=%h", i, gotV, expV);
      end
      expIdx++;
    end
    @(negedge clk);
    total++;
    if ({bus.frame_done, bus.gnt, bus.m_vld} !== 6'b01_00_00) begin
      bad++;
      $display("[TB] FAIL s1_done got done=%b gnt=%b vld=%b want done=01 gnt=00 vld=00", bus.frame_done, bus.gnt, bus.m_vld);
    end
    @(negedge clk);
    total++;
    if (bus.frame_done !== 2'b00) begin
      bad++;
      $display("[TB] FAIL s1_done_pulse got done=%b want 00", bus.frame_done);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] g;
    pushWords(12);
    bus.req = 2'b11;
    for (int f = 0; f < 3; f++) begin
      g = (f % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk);
      total++;
      if (bus.gnt !== g) begin
        bad++;
        $display("[TB] FAIL s2_grant%0d got gnt=%b want %b", f, bus.gnt, g);
      end
      for (int i = 1; i <= FL; i++) begin
        @(negedge clk);
        gotV = {bus.gnt, bus.m_vld, bus.m_last, bus.word_cnt, bus.m_data};
        expV = {g, g, (i == FL), CW'(i), wordVal(expIdx)};
        total++;
        if (gotV !== expV) begin
          bad++;
          $display("[TB] FAIL s2_f%0d_word%0d got=%h want=%h", f, i, gotV, expV);
        end
        expIdx++;
      end
      @(negedge clk);
      total++;
      if ({bus.frame_done, bus.gnt, bus.m_vld} !== {g, 4'b0000}) begin
        bad++;
        $display("[TB] FAIL s2_done%0d got done=%b gnt=%b vld=%b want done=%b gnt=00 vld=00",
                 f, bus.frame_done, bus.gnt, bus.m_vld, g);
      end
      if (f == 2) bus.req = 2'b00;
    end
    @(negedge clk);
    total++;
    if ({bus.gnt, bus.frame_done} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL s2_quiet got gnt=%b done=%b want 00 00", bus.gnt, bus.frame_done);
    end
  endtask

  task automatic test_backpressure;
    pushWords(4);
    bus.req = 2'b01;
    @(negedge clk);
    total++;
    if (bus.gnt !== 2'b01) begin
      bad++;
      $display("[TB] FAIL s3_grant got gnt=%b want 01", bus.gnt);
    end
    bus.req = 2'b00;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      gotV = {bus.gnt, bus.m_vld, bus.m_last, bus.word_cnt, bus.m_data};
      expV = {2'b01, 2'b01, 1'b0, CW'(i), wordVal(expIdx)};
      total++;
      if (gotV !== expV) begin
        bad++;
        $display("[TB] FAIL s3_word%0d got=%h want=%h", i, gotV, expV);
      end
      if (i == 1) expIdx++;
    end
    bus.m_rdy = 2'b10;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      gotV = {bus.gnt, bus.m_vld, bus.m_last, bus.word_cnt, bus.m_data};
      expV = {2'b01, 2'b01, 1'b0, CW'(2), wordVal(expIdx)};
      total++;
      if ({gotV, bus.fifo_rd_en} !== {expV, 1'b0}) begin
        bad++;
        $display("[TB] FAIL s3_hold%0d got=%h rden=%b want=%h rden=0", s, gotV, bus.fifo_rd_en, expV);
      end
    end
    expIdx++;
    bus.m_rdy = 2'b11;
    for (int i = 3; i <= FL; i++) begin
      @(negedge clk);
      gotV = {bus.gnt, bus.m_vld, bus.m_last, bus.word_cnt, bus.m_data};
      expV = {2'b01, 2'b01, (i == FL), CW'(i), wordVal(expIdx)};
      total++;
      if (gotV !== expV) begin
        bad++;
        $display("[TB] FAIL s3_word%0d got=%h want=%h", i, gotV, expV);
      end
      expIdx++;
    end
    @(negedge clk);
    total++;
    if ({bus.frame_done, bus.gnt} !== 4'b01_00) begin
      bad++;
      $display("[TB] FAIL s3_done got done=%b gnt=%b want 01 00", bus.frame_done, bus.gnt);
    end
  endtask

  task automatic test_fifo_empty;
    pushWords(2);
    bus.req = 2'b01;
    @(negedge clk);
    total++;
    if (bus.gnt !== 2'b01) begin
      bad++;
      $display("[TB] FAIL s4_grant got gnt=%b want 01", bus.gnt);
    end
    bus.req = 2'b00;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      gotV = {bus.gnt, bus.m_vld, bus.m_last, bus.word_cnt, bus.m_data};
      expV = {2'b01, 2'b01, 1'b0, CW'(i), wordVal(expIdx)};
      total++;
      if (gotV !== expV) begin
        bad++;
        $display("[TB] FAIL s4_word%0d got=%h want=%h", i, gotV, expV);
      end
      expIdx++;
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      total++;
      if ({bus.gnt, bus.m_vld, bus.m_last, bus.word_cnt} !== {2'b01, 2'b00, 1'b0, CW'(2)}) begin
        bad++;
        $display("[TB] FAIL s4_stall%0d got gnt=%b vld=%b last=%b cnt=%0d want 01 00 0 2",
                 s, bus.gnt, bus.m_vld, bus.m_last, bus.word_cnt);
      end
    end
    pushWords(2);
    for (int i = 3; i <= FL; i++) begin
      @(negedge clk);
      gotV = {bus.gnt, bus.m_vld, bus.m_last, bus.word_cnt, bus.m_data};
      expV = {2'b01, 2'b01, (i == FL), CW'(i), wordVal(expIdx)};
      total++;
      if (gotV !== expV) begin
        bad++;
        $display("[TB] FAIL s4_word%0d got=%h want=%h", i, gotV, expV);
      end
      expIdx++;
    end
    @(negedge clk);
    total++;
    if ({bus.frame_done, bus.gnt} !== 4'b01_00) begin
      bad++;
      $display("[TB] FAIL s4_done got done=%b gnt=%b want 01 00", bus.frame_done, bus.gnt);
    end
  endtask

  task automatic test_req_drop;
    logic [1:0] g;
    pushWords(8);
    bus.req = 2'b01;
    @(negedge clk);
    total++;
    if (bus.gnt !== 2'b01) begin
      bad++;
      $display("[TB] FAIL s5_grant got gnt=%b want 01", bus.gnt);
    end
    for (int f = 0; f < 2; f++) begin
      g = (f == 0) ? 2'b01 : 2'b10;
      for (int i = 1; i <= FL; i++) begin
        @(negedge clk);
        gotV = {bus.gnt, bus.m_vld, bus.m_last, bus.word_cnt, bus.m_data};
        expV = {g, g, (i == FL), CW'(i), wordVal(expIdx)};
        total++;
        if (gotV !== expV) begin
          bad++;
          $display("[TB] FAIL s5_f%0d_word%0d got=%h want=%h", f, i, gotV, expV);
        end
        expIdx++;
        if (f == 0 && i == 1) bus.req = 2'b10;
      end
      @(negedge clk);
      total++;
      if ({bus.frame_done, bus.gnt} !== {g, 2'b00}) begin
        bad++;
        $display("[TB] FAIL s5_done%0d got done=%b gnt=%b want %b 00", f, bus.frame_done, bus.gnt, g);
      end
      if (f == 0) begin
        @(negedge clk);
        total++;
        if (bus.gnt !== 2'b10) begin
          bad++;
          $display("[TB] FAIL s5_waiter_grant got gnt=%b want 10", bus.gnt);
        end
        bus.req = 2'b00;
      end
    end
  endtask

  task automatic test_reset_midframe;
    pushWords(4);
    bus.req = 2'b01;
    @(negedge clk);
    total++;
    if (bus.gnt !== 2'b01) begin
      bad++;
      $display("[TB] FAIL s6_grant got gnt=%b want 01", bus.gnt);
    end
    bus.req = 2'b00;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      gotV = {bus.gnt, bus.m_vld, bus.m_last, bus.word_cnt, bus.m_data};
      expV = {2'b01, 2'b01, 1'b0, CW'(i), wordVal(expIdx)};
      total++;
      if (gotV !== expV) begin
        bad++;
        $display("[TB] FAIL s6_word%0d got=%h want=%h", i, gotV, expV);
      end
      expIdx++;
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({bus.gnt, bus.m_vld, bus.m_last, bus.frame_done, bus.fifo_rd_en, bus.word_cnt, bus.m_data} !== '0) begin
      bad++;
      $display("[TB] FAIL s6_abort got gnt=%b vld=%b last=%b done=%b rden=%b cnt=%0d data=%h want all zero",
               bus.gnt, bus.m_vld, bus.m_last, bus.frame_done, bus.fifo_rd_en, bus.word_cnt, bus.m_data);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.req = 2'b10;
    @(negedge clk);
    total++;
    if (bus.gnt !== 2'b10) begin
      bad++;
      $display("[TB] FAIL s6_regrant got gnt=%b want 10", bus.gnt);
    end
    bus.req = 2'b00;
    pushWords(2);
    for (int i = 1; i <= FL; i++) begin
      @(negedge clk);
      gotV = {bus.gnt, bus.m_vld, bus.m_last, bus.word_cnt, bus.m_data};
      expV = {2'b10, 2'b10, (i == FL), CW'(i), wordVal(expIdx)};
      total++;
      if (gotV !== expV) begin
        bad++;
        $display("[TB] FAIL s6_word_after%0d got=%h want=%h", i, gotV, expV);
      end
      expIdx++;
    end
    @(negedge clk);
    total++;
    if ({bus.frame_done, bus.gnt} !== 4'b10_00) begin
      bad++;
      $display("[TB] FAIL s6_done got done=%b gnt=%b want 10 00", bus.frame_done, bus.gnt);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req = 2'b11;
    @(negedge clk);
    total++;
    if (bus.gnt !== 2'b01) begin
      bad++;
      $display("[TB] FAIL s6_reset_priority got gnt=%b want 01", bus.gnt);
    end
    bus.req = 2'b00;
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] starting voice_fifo_rd_arb directed run");
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_fifo_empty();
    test_req_drop();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
